// File: rtl/dmem_bus_responder.sv
// Multi-cycle load/store target for the MEM stage: one request per handshake,
// fixed LATENCY to response, byte/half/word access per RV32I funct3.
module dmem_bus_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic accept, commit;

    logic        wr_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q;

    logic [31:0] mem [2**ADDR_WIDTH];

    logic [ADDR_WIDTH-1:0] idx;
    logic [1:0]  lane;
    logic [31:0] word, ld, wd;
    logic [7:0]  bsel;
    logic [15:0] hsel;
    logic [3:0]  be;
    logic        err;

    // Next-state and handshake decode. The counter holds the number of WAIT
    // edges still to pass before the commit edge, so a request accepted at
    // edge A commits (and raises resp_valid) at edge A+LATENCY.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        commit    = 1'b0;
        req_ready = (state == IDLE) && !reset;
        case (state)
            IDLE: if (req_valid) begin
                accept    = 1'b1;
                state_nxt = WAIT;
                cnt_nxt   = 4'(LATENCY - 1);
            end
            WAIT: if (cnt == 4'd0) begin
                commit    = 1'b1;
                state_nxt = RESP;
            end else begin
                cnt_nxt = cnt - 4'd1;
            end
            RESP: if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address decode, error detection, load extraction and store lane merge
    // for the latched request.
    always_comb begin
        idx  = addr_q[ADDR_WIDTH+1:2];
        lane = addr_q[1:0];
        word = mem[idx];
        bsel = 8'(word >> {lane, 3'b000});
        hsel = 16'(word >> {addr_q[1], 4'b0000});
        case (f3_q)
            3'b000, 3'b100: err = wr_q && f3_q[2];
            3'b001, 3'b101: err = addr_q[0] || (wr_q && f3_q[2]);
            3'b010:         err = |addr_q[1:0];
            default:        err = 1'b1;
        endcase
        if (|addr_q[31:ADDR_WIDTH+2]) err = 1'b1;
        case (f3_q[1:0])
            2'b00: begin
                ld = f3_q[2] ? {24'b0, bsel} : {{24{bsel[7]}}, bsel};
                be = 4'b0001 << lane;
                wd = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                ld = f3_q[2] ? {16'b0, hsel} : {{16{hsel[15]}}, hsel};
                be = addr_q[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata_q[15:0]}};
            end
            default: begin
                ld = word;
                be = 4'b1111;
                wd = wdata_q;
            end
        endcase
    end

    // State, request latch and registered response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            wr_q       <= 1'b0;
            f3_q       <= 3'b0;
            addr_q     <= 32'b0;
            wdata_q    <= 32'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'b0;
            resp_error <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                wr_q    <= req_write;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (commit) begin
                resp_valid <= 1'b1;
                resp_rdata <= (err || wr_q) ? 32'b0 : ld;
                resp_error <= err;
            end else if (state == RESP && resp_ready) begin
                resp_valid <= 1'b0;
                resp_rdata <= 32'b0;
                resp_error <= 1'b0;
            end
        end
    end

    // Store commit on the RESP-entry edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit && wr_q && !err) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_dmem_bus_responder.sv
// Scoreboard bench: drivers push expected responses, per-DUT monitors pop and
// compare when resp_valid rises. Instance b uses LATENCY=4 for the abort case.
module tb_dmem_bus_responder;

    localparam int LAT_A = 2;
    localparam int LAT_B = 4;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, req_valid, req_write, resp_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_error;
    logic [31:0] resp_rdata;

    logic        reset_b, req_valid_b, req_write_b, resp_ready_b;
    logic [2:0]  req_funct3_b;
    logic [31:0] req_addr_b, req_wdata_b;
    logic        req_ready_b, resp_valid_b, resp_error_b;
    logic [31:0] resp_rdata_b;

    dmem_bus_responder #(.ADDR_WIDTH(10), .LATENCY(LAT_A)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error)
    );

    dmem_bus_responder #(.ADDR_WIDTH(10), .LATENCY(LAT_B)) dut_b (
        .clk(clk), .reset(reset_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_write(req_write_b), .req_funct3(req_funct3_b), .req_addr(req_addr_b),
        .req_wdata(req_wdata_b), .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
        .resp_rdata(resp_rdata_b), .resp_error(resp_error_b)
    );

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t qa[$];
    exp_t qb[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", nm);
    endtask

    // Drive one request on instance u (0 = a, 1 = b); push the expectation
    // unless the transaction is meant to be aborted.
    task automatic issue(input bit u, input bit w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wdat,
                         input logic [31:0] er, input bit ee, input bit push);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!(u ? req_ready_b : req_ready) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            timeout("req_ready_wait");
            return;
        end
        if (u) begin
            req_valid_b = 1; req_write_b = w; req_funct3_b = f3; req_addr_b = a; req_wdata_b = wdat;
        end else begin
            req_valid = 1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wdat;
        end
        @(posedge clk);
        #1;
        if (u) begin
            req_valid_b = 0; req_addr_b = 32'hFFFF_FFFF; req_wdata_b = 32'h0;
        end else begin
            req_valid = 0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
        end
        e.rdata = er;
        e.err   = ee;
        e.acc   = cyc;
        if (push) begin
            if (u) qb.push_back(e);
            else   qa.push_back(e);
        end
    endtask

    task automatic drain(input bit u);
        int n = 0;
        while (((u ? qb.size() : qa.size()) != 0 || (u ? resp_valid_b : resp_valid)) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) timeout(u ? "b_drain" : "a_drain");
    endtask

    // Monitor for instance a: latency, data and hold stability.
    initial begin
        bit          pv = 0;
        logic [31:0] hd = 0;
        logic        he = 0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (reset) pv = 0;
            else begin
                if (resp_valid && !pv) begin
                    if (qa.size() == 0) timeout("a_unexpected_resp");
                    else begin
                        e = qa.pop_front();
                        cmp("a_rdata", resp_rdata, e.rdata);
                        cmp("a_error", {31'b0, resp_error}, {31'b0, e.err});
                        cmp("a_latency", cyc - e.acc, LAT_A);
                    end
                    hd = resp_rdata;
                    he = resp_error;
                end else if (resp_valid) begin
                    cmp("a_hold_rdata", resp_rdata, hd);
                    cmp("a_hold_error", {31'b0, resp_error}, {31'b0, he});
                    cmp("a_hold_req_ready", {31'b0, req_ready}, 32'd0);
                end
                pv = resp_valid;
            end
        end
    end

    // Monitor for instance b.
    initial begin
        bit   pv = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_b) pv = 0;
            else begin
                if (resp_valid_b && !pv) begin
                    if (qb.size() == 0) timeout("b_unexpected_resp");
                    else begin
                        e = qb.pop_front();
                        cmp("b_rdata", resp_rdata_b, e.rdata);
                        cmp("b_error", {31'b0, resp_error_b}, {31'b0, e.err});
                        cmp("b_latency", cyc - e.acc, LAT_B);
                    end
                end
                pv = resp_valid_b;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1; req_valid = 0; req_write = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0; resp_ready = 1;
        reset_b = 1; req_valid_b = 0; req_write_b = 0; req_funct3_b = 0; req_addr_b = 0; req_wdata_b = 0; resp_ready_b = 1;
        repeat (2) @(negedge clk);
        cmp("rst_req_ready_high", {31'b0, req_ready}, 32'd0);
        cmp("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        reset = 0;
        reset_b = 0;
        @(negedge clk);
        cmp("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
        cmp("post_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        cmp("post_rst_rdata", resp_rdata, 32'd0);
        cmp("post_rst_error", {31'b0, resp_error}, 32'd0);

        // 1: word store/load
        issue(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1);
        issue(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1);
        // 2: byte store, byte loads
        issue(0, 1, 3'b000, 32'h11, 32'h000000AA, 32'h0, 0, 1);
        issue(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADAAEF, 0, 1);
        issue(0, 0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFAA, 0, 1);
        issue(0, 0, 3'b100, 32'h11, 32'h0, 32'h000000AA, 0, 1);
        // 3: half store, half loads
        issue(0, 1, 3'b001, 32'h12, 32'h00008001, 32'h0, 0, 1);
        issue(0, 0, 3'b001, 32'h12, 32'h0, 32'hFFFF8001, 0, 1);
        issue(0, 0, 3'b101, 32'h12, 32'h0, 32'h00008001, 0, 1);
        issue(0, 0, 3'b010, 32'h10, 32'h0, 32'h8001AAEF, 0, 1);
        issue(0, 0, 3'b001, 32'h10, 32'h0, 32'hFFFFAAEF, 0, 1);
        issue(0, 0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 0, 1);
        issue(0, 0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFEF, 0, 1);
        // 4: errors, word unchanged
        issue(0, 0, 3'b010, 32'h13, 32'h0, 32'h0, 1, 1);
        issue(0, 1, 3'b001, 32'h11, 32'h0000FFFF, 32'h0, 1, 1);
        issue(0, 0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 1);
        issue(0, 0, 3'b010, 32'h00001000, 32'h0, 32'h0, 1, 1);
        issue(0, 1, 3'b100, 32'h10, 32'h0, 32'h0, 1, 1);
        issue(0, 1, 3'b010, 32'h00001010, 32'h0, 32'h0, 1, 1);
        issue(0, 0, 3'b010, 32'h10, 32'h0, 32'h8001AAEF, 0, 1);
        drain(0);

        // 5: hold response with resp_ready low
        @(negedge clk);
        resp_ready = 0;
        issue(0, 0, 3'b010, 32'h10, 32'h0, 32'h8001AAEF, 0, 1);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) timeout("hold_resp_wait");
        repeat (5) @(negedge clk);
        cmp("hold_resp_valid", {31'b0, resp_valid}, 32'd1);
        cmp("hold_req_ready", {31'b0, req_ready}, 32'd0);
        resp_ready = 1;
        @(negedge clk);
        cmp("release_req_ready", {31'b0, req_ready}, 32'd1);
        cmp("release_resp_valid", {31'b0, resp_valid}, 32'd0);
        cmp("release_rdata", resp_rdata, 32'd0);

        // 6: reset aborts an in-flight store on instance b
        issue(1, 1, 3'b010, 32'h20, 32'h11111111, 32'h0, 0, 1);
        drain(1);
        issue(1, 1, 3'b010, 32'h20, 32'h12345678, 32'h0, 0, 0);
        @(posedge clk);
        #1;
        reset_b = 1;
        @(negedge clk);
        cmp("abort_resp_valid", {31'b0, resp_valid_b}, 32'd0);
        cmp("abort_req_ready", {31'b0, req_ready_b}, 32'd0);
        cmp("abort_rdata", resp_rdata_b, 32'd0);
        cmp("abort_error", {31'b0, resp_error_b}, 32'd0);
        repeat (5) @(negedge clk);
        reset_b = 0;
        @(negedge clk);
        cmp("abort_idle_req_ready", {31'b0, req_ready_b}, 32'd1);
        issue(1, 0, 3'b010, 32'h20, 32'h0, 32'h11111111, 0, 1);
        drain(1);

        repeat (3) @(negedge clk);
        cmp("a_queue_empty", qa.size(), 32'd0);
        cmp("b_queue_empty", qb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
